// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr0,
      StHdr1,
      StData,
      StWrite,
      StDone,
      StErr
   } state_e;

   localparam int unsigned DefaultDepth = 256;
   localparam int unsigned HdrWidth     = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian 32-bit word.
module imem_loader_byte_packer (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [31:0] word_d, word_q;
   logic [1:0]  count_d, count_q;

   always_comb begin
      word_d  = word_q;
      count_d = count_q;
      if (clear_i) begin
         word_d  = '0;
         count_d = '0;
      end else if (push_i) begin
         unique case (count_q)
            2'd0: word_d[7:0]   = byte_i;
            2'd1: word_d[15:8]  = byte_i;
            2'd2: word_d[23:16] = byte_i;
            2'd3: word_d[31:24] = byte_i;
            default: ;
         endcase
         count_d = count_q + 2'd1;
      end
   end

   // word_o includes the byte being pushed so the 4th byte can be captured on the same edge.
   assign word_o       = word_d;
   assign word_ready_o = push_i && !clear_i && (count_q == 2'd3);

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         word_q  <= '0;
         count_q <= '0;
      end else begin
         word_q  <= word_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into instruction memory,
// and holds the CPU in reset until the image is complete.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned Depth = DefaultDepth
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        start_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_wdata_o,
   output logic        cpu_hold_o,
   output logic        done_o,
   output logic        error_o,
   output logic [15:0] words_loaded_o
);

   state_e                state_q;
   logic [HdrWidth-1:0]   n_q;
   logic [15:0]           words_loaded_q;
   logic                  rx_ready_q, imem_we_q, cpu_hold_q, done_q, error_q;
   logic [31:0]           imem_addr_q, imem_wdata_q;

   logic                  xfer, start_ok, pk_push, pk_ready;
   logic [31:0]           pk_word;
   logic [HdrWidth-1:0]   hdr_n;
   logic [15:0]           wl_inc;

   assign xfer     = rx_valid_i && rx_ready_q;
   assign start_ok = start_i && (state_q == StIdle || state_q == StDone || state_q == StErr);
   assign pk_push  = xfer && (state_q == StData);
   assign hdr_n    = {rx_data_i, n_q[7:0]};
   assign wl_inc   = words_loaded_q + 16'd1;

   imem_loader_byte_packer u_packer (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .clear_i     (start_ok),
      .push_i      (pk_push),
      .byte_i      (rx_data_i),
      .word_o      (pk_word),
      .word_ready_o(pk_ready)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q        <= StIdle;
         n_q            <= '0;
         words_loaded_q <= '0;
         rx_ready_q     <= 1'b0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= '0;
         cpu_hold_q     <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (start_i) begin
                  state_q        <= StHdr0;
                  words_loaded_q <= '0;
                  rx_ready_q     <= 1'b1;
                  cpu_hold_q     <= 1'b1;
                  done_q         <= 1'b0;
                  error_q        <= 1'b0;
               end
            end
            StHdr0: begin
               if (xfer) begin
                  n_q[7:0] <= rx_data_i;
                  state_q  <= StHdr1;
               end
            end
            StHdr1: begin
               if (xfer) begin
                  n_q <= hdr_n;
                  if (hdr_n == '0) begin
                     state_q    <= StDone;
                     rx_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else if (32'(hdr_n) > Depth) begin
                     state_q    <= StErr;
                     rx_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                  end else begin
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (pk_ready) begin
                  state_q      <= StWrite;
                  rx_ready_q   <= 1'b0;
                  imem_we_q    <= 1'b1;
                  imem_addr_q  <= {14'd0, words_loaded_q, 2'b00};
                  imem_wdata_q <= pk_word;
               end
            end
            StWrite: begin
               imem_we_q      <= 1'b0;
               words_loaded_q <= wl_inc;
               // Release the core only after the final write cycle has completed.
               if (wl_inc == n_q) begin
                  state_q    <= StDone;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
               end else begin
                  state_q    <= StData;
                  rx_ready_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rx_ready_o     = rx_ready_q;
   assign imem_we_o      = imem_we_q;
   assign imem_addr_o    = imem_addr_q;
   assign imem_wdata_o   = imem_wdata_q;
   assign cpu_hold_o     = cpu_hold_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign words_loaded_o = words_loaded_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into instruction memory at consecutive word-aligned byte addresses. Holds the CPU core in reset until the image is fully written, then releases it. Sits between the host byte link (UART receiver or testbench) and the instruction memory write port.

## Interface
- DEPTH, 256, instruction memory capacity in 32-bit words
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets the block)
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- rx_valid  in  1  byte on rx_data is valid
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_addr  out  32  byte address of the word being written (word_index*4)
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  hold CPU core in reset
- done  out  1  image loaded; level, held until next start or reset
- error  out  1  header word count exceeded DEPTH; level, sticky
- words_loaded  out  16  number of words written in the current load

## Operation
- Stream format: 2-byte header N (little-endian word count, first byte = N[7:0]), then 4*N bytes, each word little-endian (first byte -> bits [7:0]).
- Byte transfer occurs only on a cycle with rx_valid && rx_ready; rx_valid without rx_ready is not consumed.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE: rx_ready=0, cpu_hold=1. start -> HDR0, words_loaded cleared.
- HDR0: rx_ready=1; on transfer latch N[7:0] -> HDR1.
- HDR1: rx_ready=1; on transfer latch N[15:8]; N==0 -> DONE; N>DEPTH -> ERR; else -> DATA with byte counter 0.
- DATA: rx_ready=1; each transfer shifts byte into lane (byte_count); on 4th byte -> WRITE.
- WRITE: rx_ready=0; imem_we=1, imem_addr=words_loaded*4, imem_wdata=assembled word; words_loaded increments at end of cycle; if new words_loaded==N -> DONE else -> DATA.
- DONE: done=1, cpu_hold=0, rx_ready=0; start -> HDR0 (cpu_hold reasserts same edge).
- ERR: error=1, cpu_hold=1, rx_ready=0, no writes; start -> HDR0 clears error.
- start ignored in HDR0/HDR1/DATA/WRITE.
- Address arithmetic: 32-bit, word index never exceeds DEPTH-1 (guaranteed by header check), no wrap.

## Timing
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, state=IDLE.
- Reset mid-load: next cycle all outputs at reset values; partially written memory left as is; no further writes.
- Latency: imem_we asserts the cycle after the 4th byte of a word is accepted; exactly one cycle wide.
- Max throughput: 5 cycles per word (4 transfers + 1 WRITE).
- done/cpu_hold change on the edge leaving WRITE for the last word; last write and cpu_hold release never share a cycle.
- imem_addr/imem_wdata registered; stable while imem_we=1.

## Structure
- Shared package: state enum type, DEPTH default, header width constant (16).
- One sub-module: byte_packer (4-byte little-endian shift/assemble with byte counter, clear and word_ready outputs).
- Top holds FSM, header register, word counter, output registers.

## Test plan
- Reset low 3 cycles then high -> cpu_hold=1, rx_ready=0, done=0, imem_we=0; start, header 0x02,0x00, bytes 13 05 00 00 93 05 10 00 -> writes addr 0x0 data 0x00000513, addr 0x4 data 0x00100593, then done=1, cpu_hold=0, words_loaded=2.
- Backpressure: rx_valid held high continuously -> rx_ready drops during each WRITE cycle, no byte lost or duplicated; 4-word image matches exactly.
- Header N=0 -> DONE immediately after header, no imem_we pulse, cpu_hold=0.
- Header N=257 (0x01,0x01) with DEPTH=256 -> error=1, cpu_hold=1, zero writes; subsequent start + valid 1-word image -> error=0, done=1.
- Reset low after 6 data bytes of a 3-word load -> exactly one write issued, all outputs at reset values next cycle; fresh load then succeeds.
- start pulsed during DATA -> ignored; load completes with correct words_loaded; start in DONE restarts with cpu_hold=1.
